axi_mem_port_arbiter: RTL

//  Shares one single-port SRAM macro (CEN/WEN/A/D/BE/Q, active-low CEN/WEN) between a high-priority

---
 rtl/axi_mem_arb_pkg.sv | 13 +
 rtl/axi_mem_port_arbiter_if.sv | 59 +++++
 rtl/axi_mem_arb_wait_cnt.sv | 39 +++
 rtl/axi_mem_port_arbiter.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/axi_mem_arb_pkg.sv
// Shared types for the SRAM port arbiter: read-return owner encoding and perf counter width.
// Optional perf counters are enabled with AXI_MEM_ARB_PERF_EN.
package axi_mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_HP   = 2'd1,
        OWN_LPR  = 2'd2
    } owner_t;

    localparam int PERF_CNT_WIDTH = 32;

endpackage

// File: rtl/axi_mem_port_arbiter_if.sv
// Client/SRAM bundle for axi_mem_port_arbiter; slave = arbiter side, master = clients plus SRAM macro.
// Handshake: a *_req_i is taken in the cycle its *_gnt_o is high; read data returns one cycle later with *_rvalid_o.
interface axi_mem_port_arbiter_if #(
    parameter int MEM_ADDR_WIDTH = 13,
    parameter int DATA_WIDTH     = 64
);
    localparam int NUMBYTES = DATA_WIDTH / 8;

    logic                      HP_req_i;
    logic                      HP_we_i;
    logic [MEM_ADDR_WIDTH-1:0] HP_addr_i;
    logic [DATA_WIDTH-1:0]     HP_wdata_i;
    logic [NUMBYTES-1:0]       HP_be_i;
    logic                      HP_gnt_o;
    logic                      HP_rvalid_o;
    logic [DATA_WIDTH-1:0]     HP_rdata_o;

    logic                      LPR_req_i;
    logic [MEM_ADDR_WIDTH-1:0] LPR_addr_i;
    logic                      LPR_gnt_o;
    logic                      LPR_rvalid_o;
    logic [DATA_WIDTH-1:0]     LPR_rdata_o;

    logic                      LPW_req_i;
    logic [MEM_ADDR_WIDTH-1:0] LPW_addr_i;
    logic [DATA_WIDTH-1:0]     LPW_wdata_i;
    logic [NUMBYTES-1:0]       LPW_be_i;
    logic                      LPW_gnt_o;

    logic                      CEN;
    logic                      WEN;
    logic [MEM_ADDR_WIDTH-1:0] A;
    logic [DATA_WIDTH-1:0]     D;
    logic [NUMBYTES-1:0]       BE;
    logic [DATA_WIDTH-1:0]     Q;

    modport slave (
        input  HP_req_i, HP_we_i, HP_addr_i, HP_wdata_i, HP_be_i,
        output HP_gnt_o, HP_rvalid_o, HP_rdata_o,
        input  LPR_req_i, LPR_addr_i,
        output LPR_gnt_o, LPR_rvalid_o, LPR_rdata_o,
        input  LPW_req_i, LPW_addr_i, LPW_wdata_i, LPW_be_i,
        output LPW_gnt_o,
        output CEN, WEN, A, D, BE,
        input  Q
    );

    modport master (
        output HP_req_i, HP_we_i, HP_addr_i, HP_wdata_i, HP_be_i,
        input  HP_gnt_o, HP_rvalid_o, HP_rdata_o,
        output LPR_req_i, LPR_addr_i,
        input  LPR_gnt_o, LPR_rvalid_o, LPR_rdata_o,
        output LPW_req_i, LPW_addr_i, LPW_wdata_i, LPW_be_i,
        input  LPW_gnt_o,
        input  CEN, WEN, A, D, BE,
        output Q
    );

endinterface

// File: rtl/axi_mem_arb_wait_cnt.sv
// Counts consecutive cycles an LP request is left waiting and raises force_lp once the bound is hit.
module axi_mem_arb_wait_cnt #(
    parameter int LP_MAX_WAIT    = 8,
    parameter int WAIT_CNT_WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic lp_req,
    input  logic lp_gnt,
    output logic force_lp
);

    logic [WAIT_CNT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!lp_req || lp_gnt) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != '1) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // A bound of zero means LP never overrides HP.
    if (LP_MAX_WAIT == 0) begin : g_strict
        assign force_lp = 1'b0;
    end else begin : g_bounded
        assign force_lp = lp_req && (wait_cnt_q >= WAIT_CNT_WIDTH'(LP_MAX_WAIT));
    end

endmodule

// File: rtl/axi_mem_port_arbiter.sv
// Single-port SRAM arbiter: HP priority with bounded LP wait, LP read/write round robin, tagged read return.
// Define AXI_MEM_ARB_PERF_EN to add the PERF_* clear input and saturating perf counters.
module axi_mem_port_arbiter
    import axi_mem_arb_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 13,
    parameter int DATA_WIDTH     = 64,
    parameter int LP_MAX_WAIT    = 8,
    parameter int WAIT_CNT_WIDTH = 8
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    axi_mem_port_arbiter_if.slave     bus
`ifdef AXI_MEM_ARB_PERF_EN
    ,
    input  logic                      PERF_CLR_i,
    output logic [PERF_CNT_WIDTH-1:0] PERF_LP_WAIT_o,
    output logic [PERF_CNT_WIDTH-1:0] PERF_FORCED_o
`endif
);

    localparam int NUMBYTES = DATA_WIDTH / 8;

    logic   lp_any, force_lp, hp_win, lp_ok, lpw_win, lpr_win, lp_gnt;
    logic   rr_flag_q, rr_flag_d;
    owner_t owner_q, owner_d;

    logic                      cen, wen;
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [NUMBYTES-1:0]       be;

    axi_mem_arb_wait_cnt #(
        .LP_MAX_WAIT    (LP_MAX_WAIT),
        .WAIT_CNT_WIDTH (WAIT_CNT_WIDTH)
    ) u_wait_cnt (
        .clk      (ACLK),
        .rst_n    (ARESETn),
        .lp_req   (lp_any),
        .lp_gnt   (lp_gnt),
        .force_lp (force_lp)
    );

    // rr_flag_q = 0 favours the write controller, 1 favours the read controller.
    assign lp_any  = bus.LPR_req_i | bus.LPW_req_i;
    assign hp_win  = ARESETn & bus.HP_req_i & ~force_lp;
    assign lp_ok   = ARESETn & lp_any & ~hp_win;
    assign lpw_win = lp_ok & bus.LPW_req_i & (~bus.LPR_req_i | ~rr_flag_q);
    assign lpr_win = lp_ok & bus.LPR_req_i & ~lpw_win;
    assign lp_gnt  = lpw_win | lpr_win;

    always_comb begin
        rr_flag_d = rr_flag_q ^ lp_gnt;
        owner_d   = OWN_NONE;
        if (hp_win && !bus.HP_we_i) begin
            owner_d = OWN_HP;
        end else if (lpr_win) begin
            owner_d = OWN_LPR;
        end
    end

    always_comb begin
        cen   = 1'b1;
        wen   = 1'b1;
        addr  = '0;
        wdata = '0;
        be    = '0;
        if (hp_win) begin
            cen  = 1'b0;
            wen  = ~bus.HP_we_i;
            addr = bus.HP_addr_i;
            if (bus.HP_we_i) begin
                wdata = bus.HP_wdata_i;
                be    = bus.HP_be_i;
            end
        end else if (lpw_win) begin
            cen   = 1'b0;
            wen   = 1'b0;
            addr  = bus.LPW_addr_i;
            wdata = bus.LPW_wdata_i;
            be    = bus.LPW_be_i;
        end else if (lpr_win) begin
            cen  = 1'b0;
            addr = bus.LPR_addr_i;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            rr_flag_q <= 1'b0;
            owner_q   <= OWN_NONE;
        end else begin
            rr_flag_q <= rr_flag_d;
            owner_q   <= owner_d;
        end
    end

    assign bus.HP_gnt_o  = hp_win;
    assign bus.LPR_gnt_o = lpr_win;
    assign bus.LPW_gnt_o = lpw_win;
    assign bus.CEN       = cen;
    assign bus.WEN       = wen;
    assign bus.A         = addr;
    assign bus.D         = wdata;
    assign bus.BE        = be;

    // A read still in flight when reset asserts is dropped, not returned.
    assign bus.HP_rvalid_o  = ARESETn && (owner_q == OWN_HP);
    assign bus.LPR_rvalid_o = ARESETn && (owner_q == OWN_LPR);
    assign bus.HP_rdata_o   = bus.Q;
    assign bus.LPR_rdata_o  = bus.Q;

`ifdef AXI_MEM_ARB_PERF_EN
    logic [PERF_CNT_WIDTH-1:0] perf_lp_wait_q, perf_lp_wait_d;
    logic [PERF_CNT_WIDTH-1:0] perf_forced_q, perf_forced_d;

    always_comb begin
        perf_lp_wait_d = perf_lp_wait_q;
        perf_forced_d  = perf_forced_q;
        if (PERF_CLR_i) begin
            perf_lp_wait_d = '0;
            perf_forced_d  = '0;
        end else begin
            if (lp_any && !lp_gnt && perf_lp_wait_q != '1) begin
                perf_lp_wait_d = perf_lp_wait_q + 1'b1;
            end
            if (force_lp && lp_gnt && perf_forced_q != '1) begin
                perf_forced_d = perf_forced_q + 1'b1;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            perf_lp_wait_q <= '0;
            perf_forced_q  <= '0;
        end else begin
            perf_lp_wait_q <= perf_lp_wait_d;
            perf_forced_q  <= perf_forced_d;
        end
    end

    assign PERF_LP_WAIT_o = perf_lp_wait_q;
    assign PERF_FORCED_o  = perf_forced_q;
`endif

endmodule
